// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer: step operations and FSM states.
package shift_pkg;

  // Step operations applied by the 4-bit shift stage
  localparam logic [1:0] OP_HOLD = 2'b00;  // d = i
  localparam logic [1:0] OP_SHL  = 2'b01;  // shift left, zero fill
  localparam logic [1:0] OP_SHR  = 2'b10;  // shift right, zero fill
  localparam logic [1:0] OP_REV  = 2'b11;  // bit reverse

  // Sequencer states; encoding 2'd3 is unused and behaves as idle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage4.sv
// Purely combinational 4-bit shift stage: one 4:1 mux per output bit selects
// between hold, left-shift, right-shift and bit-reverse sources.
module shift_stage4
  import shift_pkg::*;
(
  input  logic [3:0] i,
  input  logic [1:0] op,
  output logic [3:0] d
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      logic shl_src;
      logic shr_src;
      logic rev_src;
      logic d_bit;

      // Left shift pulls from the next-lower bit; bit 0 takes the zero fill
      if (gi == 0) begin : g_shl_fill
        assign shl_src = 1'b0;
      end else begin : g_shl_pass
        assign shl_src = i[gi-1];
      end

      // Right shift pulls from the next-higher bit; bit 3 takes the zero fill
      if (gi == 3) begin : g_shr_fill
        assign shr_src = 1'b0;
      end else begin : g_shr_pass
        assign shr_src = i[gi+1];
      end

      assign rev_src = i[3-gi];

      // 4:1 mux for this output bit
      always_comb begin
        d_bit = i[gi];
        case (op)
          OP_HOLD: d_bit = i[gi];
          OP_SHL:  d_bit = shl_src;
          OP_SHR:  d_bit = shr_src;
          OP_REV:  d_bit = rev_src;
          default: d_bit = i[gi];
        endcase
      end

      assign d[gi] = d_bit;
    end
  endgenerate

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step wrapper around shift_stage4: loads a word, then applies the
// latched operation once per clock for a programmed number of steps, feeding
// the result back each step. Presents busy/done handshake to the consumer.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [3:0]       din,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic [3:0]       dout,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t           state_reg;
  logic [3:0]       dout_reg;
  logic [1:0]       op_q_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [3:0]       stage_next;

  // Single shared stage, always fed back from the data register and frozen op
  shift_stage4 u_stage (
    .i  (dout_reg),
    .op (op_q_reg),
    .d  (stage_next)
  );

  // Sequencer FSM with registered data, step counter and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      dout_reg      <= 4'b0000;
      op_q_reg      <= OP_HOLD;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_RUN: begin
          // One step per edge; the step that consumes the last count ends the run
          dout_reg      <= stage_next;
          remaining_reg <= remaining_reg - CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end
        S_DONE: begin
          // Done is a single-cycle pulse; busy drops together with it
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          // Idle (and the unused encoding): load wins over start
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          if (load) begin
            dout_reg <= din;
          end else if (start) begin
            op_q_reg      <= op;
            remaining_reg <= count;
            busy_reg      <= 1'b1;
            if (count == '0) begin
              // Zero steps: skip straight to the done pulse, data untouched
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_RUN;
            end
          end
        end
      endcase
    end
  end

  assign dout = dout_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign zero = (dout_reg == 4'b0000);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_shift_sequencer;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [3:0]       din;
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [3:0]       dout;
  logic             busy;
  logic             done;
  logic             zero;

  int n_checks = 0;
  int n_fails  = 0;

  shift_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .start (start),
    .op    (op),
    .count (count),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Reference step function from the operation table
  function automatic logic [3:0] step_f(input logic [3:0] x, input logic [1:0] o);
    logic [3:0] r;
    case (o)
      2'b01:   r = 4'((x * 2) % 16);
      2'b10:   r = x / 2;
      2'b11:   for (int k = 0; k < 4; k++) r[k] = x[3-k];
      default: r = x;
    endcase
    return r;
  endfunction

  // Model: the whole sequence of future results is computed when start is accepted
  logic [3:0] m_dout = 4'b0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [3:0] m_q[$];
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_dout = 4'b0; m_busy = 1'b0; m_done = 1'b0; m_q.delete(); m_valid = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_dout = m_q.pop_front();
      if (m_q.size() == 0) m_done = 1'b1;
    end else if (load) begin
      m_dout = din;
    end else if (start) begin
      logic [3:0] t;
      t = m_dout;
      for (int k = 0; k < int'(count); k++) begin
        t = step_f(t, op);
        m_q.push_back(t);
      end
      m_busy = 1'b1;
      if (count == 0) m_done = 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (dout !== m_dout || busy !== m_busy || done !== m_done || zero !== (m_dout == 4'b0)) begin
        n_fails++;
        $display("FAIL model t=%0t: dout=%b busy=%b done=%b zero=%b, required dout=%b busy=%b done=%b zero=%b",
                 $time, dout, busy, done, zero, m_dout, m_busy, m_done, (m_dout == 4'b0));
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] d);
    load = 1'b1; din = d;
    tick(1);
    load = 1'b0; din = 4'hx;
  endtask

  task automatic do_start(input logic [1:0] o, input logic [CNT_W-1:0] c);
    start = 1'b1; op = o; count = c;
    tick(1);
    start = 1'b0; op = 2'b00; count = '0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 40 && done !== 1'b1; i++) tick(1);
    if (done !== 1'b1) begin
      n_checks++; n_fails++;
      $display("FAIL %s: done not seen within 40 cycles, required done=1", name);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = 4'b0; start = 1'b0; op = 2'b00; count = '0;
    tick(2);
    check("reset_dout", dout, 4'b0000);
    check("reset_flags", {1'b0, busy, done, zero}, 4'b0001);
    rst = 1'b0;

    // 1) SHL x2 from 1011
    do_load(4'b1011);
    do_start(2'b01, 3'd2);
    check("t1_busy", {3'b0, busy}, 4'b0001);
    tick(1); check("t1_step1", dout, 4'b0110);
    tick(1); check("t1_step2", dout, 4'b1100);
    check("t1_done", {3'b0, done}, 4'b0001);
    tick(1); check("t1_idle", {2'b0, busy, done}, 4'b0000);

    // 2) SHR x3 from 1000, then one more to zero
    do_load(4'b1000);
    do_start(2'b10, 3'd3);
    wait_done("t2a");
    check("t2_dout", dout, 4'b0001);
    check("t2_zero0", {3'b0, zero}, 4'b0000);
    tick(1);
    do_start(2'b10, 3'd1);
    wait_done("t2b");
    check("t2_dout_zero", dout, 4'b0000);
    check("t2_zero1", {3'b0, zero}, 4'b0001);
    tick(1);

    // 3) REV once then twice
    do_load(4'b0001);
    do_start(2'b11, 3'd1);
    wait_done("t3a");
    check("t3_rev1", dout, 4'b1000);
    tick(1);
    do_start(2'b11, 3'd2);
    wait_done("t3b");
    check("t3_rev2", dout, 4'b1000);
    tick(1);

    // 4) count=0: done on the next cycle, data unchanged
    do_load(4'b0110);
    do_start(2'b01, 3'd0);
    check("t4_done", {3'b0, done}, 4'b0001);
    check("t4_dout", dout, 4'b0110);
    tick(1);

    // 5) inputs ignored while busy; load beats start in idle
    do_load(4'b0011);
    do_start(2'b01, 3'd5);
    tick(1);
    start = 1'b1; load = 1'b1; din = 4'b1111; op = 2'b10;
    tick(1);
    start = 1'b0; load = 1'b0; op = 2'b00;
    check("t5_mid", dout, 4'b1100);
    wait_done("t5");
    check("t5_final", dout, 4'b0000);
    tick(1);
    load = 1'b1; din = 4'b0101; start = 1'b1; op = 2'b01; count = 3'd2;
    tick(1);
    load = 1'b0; start = 1'b0; count = '0;
    check("t5_load_prio", dout, 4'b0101);
    check("t5_no_start", {3'b0, busy}, 4'b0000);

    // 6) reset in the second RUN cycle aborts with no done
    do_load(4'b0101);
    do_start(2'b11, 3'd5);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_dout", dout, 4'b0000);
    check("t6_rst_flags", {2'b0, busy, done}, 4'b0000);
    tick(8);
    do_load(4'b1001);
    do_start(2'b01, 3'd2);
    wait_done("t6");
    check("t6_after", dout, 4'b0100);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
